// File: rtl/fpu_sched_pkg.sv
// fpu_sched_pkg: shared types and constants for the FPU operation scheduler
package fpu_sched_pkg;
   localparam int EXP_W   = 7;
   localparam int MANT_W  = 15;
   localparam int ERR_OP  = 0;
   localparam int ERR_FPU = 1;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_MOV = 2'b01,
      OP_CLR = 2'b10,
      OP_RSV = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_START,
      S_WAIT_DONE,
      S_WB
   } state_e;

   typedef struct packed {
      op_e        op;
      logic [1:0] dst;
      logic [1:0] sa;
      logic [1:0] sb;
   } cmd_t;

   typedef struct packed {
      logic [EXP_W-1:0]  e;
      logic [MANT_W-1:0] m;
   } fp_t;
endpackage

// File: rtl/fpu_cmd_fifo.sv
// fpu_cmd_fifo: synchronous show-ahead FIFO of 8-bit scheduler commands
module fpu_cmd_fifo #(
   parameter int DEPTH = 2
) (
   input  logic       clk_10MHZ,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full    = cnt_q == (AW+1)'(DEPTH);
   assign empty   = cnt_q == '0;
   assign dout    = mem_q[rd_q];
   assign do_pop  = pop && !empty;
   // a simultaneous pop frees the slot, so a push is still legal when full
   assign do_push = push && (!full || do_pop);

   always_comb begin
      mem_d = mem_q;
      wr_d  = do_push ? wr_q + AW'(1) : wr_q;
      rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (do_push) mem_d[wr_q] = din;
   end

   always_ff @(posedge clk_10MHZ) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/fpu_op_sched.sv
// fpu_op_sched: queues register-file commands and sequences the shared FPU
module fpu_op_sched
   import fpu_sched_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int START_WAIT   = 4,
   parameter int DONE_TIMEOUT = 255
) (
   input  logic        clk_10MHZ,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [1:0]  cmd_dst,
   input  logic [1:0]  cmd_sa,
   input  logic [1:0]  cmd_sb,
   input  logic        host_wr_en,
   output logic        host_wr_ready,
   input  logic [1:0]  host_wr_idx,
   input  logic [6:0]  host_wr_e,
   input  logic [14:0] host_wr_m,
   input  logic [1:0]  host_rd_idx,
   output logic [6:0]  host_rd_e,
   output logic [14:0] host_rd_m,
   output logic        fpu_add,
   output logic [6:0]  fpu_a_e,
   output logic [14:0] fpu_a_m,
   output logic [6:0]  fpu_b_e,
   output logic [14:0] fpu_b_m,
   input  logic        fpu_idle,
   input  logic [6:0]  fpu_res_e,
   input  logic [14:0] fpu_res_m,
   output logic        busy,
   output logic        done,
   output logic [1:0]  err,
   input  logic        err_clr
);
   state_e     state_q, state_d;
   cmd_t       cmd_q, cmd_d, head;
   logic [7:0] tmr_q, tmr_d;
   fp_t        a_q, a_d, b_q, b_d, res_q, res_d, rd_q, rd_d;
   fp_t        rf_q [4];
   fp_t        rf_d [4];
   logic       add_q, add_d, done_q, done_d;
   logic [1:0] err_q, err_d;
   logic [7:0] fifo_dout;
   logic       fifo_full, fifo_empty, pop;

   fpu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_10MHZ (clk_10MHZ),
      .rst_n     (rst_n),
      .push      (cmd_valid && cmd_ready),
      .pop       (pop),
      .din       ({cmd_op, cmd_dst, cmd_sa, cmd_sb}),
      .dout      (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign head          = cmd_t'(fifo_dout);
   assign pop           = state_q == S_IDLE && !fifo_empty && fpu_idle;
   assign cmd_ready     = !fifo_full;
   assign host_wr_ready = state_q != S_WB;
   assign busy          = !fifo_empty || state_q != S_IDLE;
   assign fpu_add       = add_q;
   assign {fpu_a_e, fpu_a_m} = a_q;
   assign {fpu_b_e, fpu_b_m} = b_q;
   assign {host_rd_e, host_rd_m} = rd_q;
   assign done          = done_q;
   assign err           = err_q;

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      tmr_d   = tmr_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      rf_d    = rf_q;
      add_d   = 1'b0;
      done_d  = 1'b0;
      err_d   = err_clr ? 2'b00 : err_q;
      rd_d    = rf_q[host_rd_idx];
      if (host_wr_en && host_wr_ready) rf_d[host_wr_idx] = {host_wr_e, host_wr_m};
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               cmd_d   = head;
               tmr_d   = '0;
               state_d = head.op == OP_ADD ? S_ISSUE : head.op == OP_RSV ? S_IDLE : S_WB;
               if (head.op == OP_RSV) begin
                  err_d[ERR_OP] = 1'b1;
                  done_d        = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            // operands are captured here and held until the next ISSUE
            a_d     = rf_q[cmd_q.sa];
            b_d     = rf_q[cmd_q.sb];
            add_d   = 1'b1;
            tmr_d   = '0;
            state_d = S_WAIT_START;
         end
         S_WAIT_START: begin
            if (!fpu_idle) begin
               tmr_d   = '0;
               state_d = S_WAIT_DONE;
            end else if (tmr_q == 8'(START_WAIT - 1)) begin
               err_d[ERR_FPU] = 1'b1;
               done_d         = 1'b1;
               state_d        = S_IDLE;
            end else begin
               tmr_d = tmr_q + 8'd1;
            end
         end
         S_WAIT_DONE: begin
            if (fpu_idle) begin
               res_d   = {fpu_res_e, fpu_res_m};
               state_d = S_WB;
            end else if (tmr_q == 8'(DONE_TIMEOUT - 1)) begin
               err_d[ERR_FPU] = 1'b1;
               done_d         = 1'b1;
               state_d        = S_IDLE;
            end else begin
               tmr_d = tmr_q + 8'd1;
            end
         end
         S_WB: begin
            rf_d[cmd_q.dst] = cmd_q.op == OP_ADD ? res_q : cmd_q.op == OP_MOV ? rf_q[cmd_q.sa] : '0;
            done_d          = 1'b1;
            state_d         = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_10MHZ) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cmd_q   <= '0;
         tmr_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         rf_q    <= '{default: '0};
         rd_q    <= '0;
         add_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         tmr_q   <= tmr_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         rf_q    <= rf_d;
         rd_q    <= rd_d;
         add_q   <= add_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_fpu_op_sched.sv
// tb_fpu_op_sched: directed bench for fpu_op_sched with a behavioural FPU model
module tb_fpu_op_sched;
   logic        clk_10MHZ = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_op, cmd_dst, cmd_sa, cmd_sb;
   logic        host_wr_en, host_wr_ready;
   logic [1:0]  host_wr_idx, host_rd_idx;
   logic [6:0]  host_wr_e, host_rd_e;
   logic [14:0] host_wr_m, host_rd_m;
   logic        fpu_add;
   logic [6:0]  fpu_a_e, fpu_b_e;
   logic [14:0] fpu_a_m, fpu_b_m;
   logic        fpu_idle = 1'b1;
   logic [6:0]  fpu_res_e = '0;
   logic [14:0] fpu_res_m = '0;
   logic        busy, done, err_clr;
   logic [1:0]  err;

   int n_chk = 0, n_err = 0, cyc = 0, add_cnt = 0, done_cnt = 0;
   int fpu_mode = 0, fpu_busy = 10, fpu_cnt = 0;
   int t0, t1, ta, a0, d0;

   fpu_op_sched dut (
      .clk_10MHZ(clk_10MHZ), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_dst(cmd_dst), .cmd_sa(cmd_sa), .cmd_sb(cmd_sb),
      .host_wr_en(host_wr_en), .host_wr_ready(host_wr_ready), .host_wr_idx(host_wr_idx),
      .host_wr_e(host_wr_e), .host_wr_m(host_wr_m),
      .host_rd_idx(host_rd_idx), .host_rd_e(host_rd_e), .host_rd_m(host_rd_m),
      .fpu_add(fpu_add), .fpu_a_e(fpu_a_e), .fpu_a_m(fpu_a_m),
      .fpu_b_e(fpu_b_e), .fpu_b_m(fpu_b_m), .fpu_idle(fpu_idle),
      .fpu_res_e(fpu_res_e), .fpu_res_m(fpu_res_m),
      .busy(busy), .done(done), .err(err), .err_clr(err_clr)
   );

   always #50 clk_10MHZ = ~clk_10MHZ;

   always @(posedge clk_10MHZ) begin
      cyc <= cyc + 1;
      if (fpu_add) add_cnt <= add_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   // FPU model: mode 0 normal (doubles operand A), 1 ignores start, 2 hangs busy, 3 forced busy
   always @(posedge clk_10MHZ) begin
      if (fpu_mode == 3) fpu_idle <= 1'b0;
      else if (fpu_add && fpu_mode != 1) begin
         fpu_idle  <= 1'b0;
         fpu_cnt   <= fpu_busy;
         fpu_res_e <= fpu_a_e + 7'd1;
         fpu_res_m <= fpu_a_m;
      end else if (fpu_mode != 2) begin
         if (fpu_cnt > 1) fpu_cnt <= fpu_cnt - 1;
         else begin
            fpu_cnt  <= 0;
            fpu_idle <= 1'b1;
         end
      end
   end

   task automatic tick;
      @(negedge clk_10MHZ);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic hw(input logic [1:0] idx, input logic [6:0] e, input logic [14:0] m);
      host_wr_en = 1'b1; host_wr_idx = idx; host_wr_e = e; host_wr_m = m;
      tick;
      host_wr_en = 1'b0;
   endtask

   task automatic push(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] sa, input logic [1:0] sb);
      cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_sa = sa; cmd_sb = sb;
      tick;
   endtask

   task automatic rdchk(input string tag, input logic [1:0] idx, input logic [6:0] e, input logic [14:0] m);
      host_rd_idx = idx;
      tick;
      chk(tag, 32'({host_rd_e, host_rd_m}), 32'({e, m}));
   endtask

   task automatic wait_done(input string tag, output int t);
      for (int k = 0; k < 400 && done !== 1'b1; k++) tick;
      t = cyc;
      chk(tag, 32'(done), 32'd1);
   endtask

   task automatic wait_add(input string tag, output int t);
      for (int k = 0; k < 40 && fpu_add !== 1'b1; k++) tick;
      t = cyc;
      chk(tag, 32'(fpu_add), 32'd1);
   endtask

   task automatic wait_err1(input string tag);
      for (int k = 0; k < 400 && err[1] !== 1'b1; k++) tick;
      chk(tag, 32'(err), 32'd2);
   endtask

   task automatic wait_idle;
      for (int k = 0; k < 60 && fpu_idle !== 1'b1; k++) tick;
      chk("fpu_idle_back", 32'(fpu_idle), 32'd1);
      tick;
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_sa = '0; cmd_sb = '0;
      host_wr_en = 1'b0; host_wr_idx = '0; host_wr_e = '0; host_wr_m = '0; host_rd_idx = '0;
      err_clr = 1'b0;
      tick; tick;
      chk("rst_fpu_add", 32'(fpu_add), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rd", 32'({host_rd_e, host_rd_m}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      rst_n = 1'b1;
      tick;

      // ADD of two equal operands: FPU returns doubled value
      hw(2'd0, 7'd3, 15'h4000);
      hw(2'd1, 7'd3, 15'h4000);
      a0 = add_cnt; d0 = done_cnt;
      push(2'b00, 2'd2, 2'd0, 2'd1);
      cmd_valid = 1'b0;
      wait_done("add_done", t1);
      chk("add_opa_held", 32'({fpu_a_e, fpu_a_m}), 32'({7'd3, 15'h4000}));
      tick;
      chk("add_done_one_cycle", 32'(done), 32'd0);
      chk("add_pulses", 32'(add_cnt - a0), 32'd1);
      chk("add_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("add_err", 32'(err), 32'd0);
      rdchk("add_reg2", 2'd2, 7'd4, 15'h4000);

      // MOV then CLR back to back
      a0 = add_cnt;
      push(2'b01, 2'd3, 2'd0, 2'd0);
      push(2'b10, 2'd0, 2'd0, 2'd0);
      cmd_valid = 1'b0;
      wait_done("mov_done", t0);
      tick;
      wait_done("clr_done", t1);
      chk("mov_clr_gap", 32'(t1 - t0), 32'd2);
      tick;
      chk("mov_clr_no_add", 32'(add_cnt - a0), 32'd0);
      rdchk("mov_reg3", 2'd3, 7'd3, 15'h4000);
      rdchk("clr_reg0", 2'd0, 7'd0, 15'h0);

      // FIFO fill while the FPU is held busy
      fpu_mode = 3;
      tick; tick;
      chk("fifo_ready_0", 32'(cmd_ready), 32'd1);
      push(2'b00, 2'd0, 2'd1, 2'd1);
      chk("fifo_ready_1", 32'(cmd_ready), 32'd1);
      push(2'b00, 2'd1, 2'd2, 2'd2);
      cmd_op = 2'b00; cmd_dst = 2'd3; cmd_sa = 2'd0; cmd_sb = 2'd0;
      chk("fifo_full", 32'(cmd_ready), 32'd0);
      tick;
      chk("fifo_full_hold", 32'(cmd_ready), 32'd0);
      chk("fifo_busy", 32'(busy), 32'd1);
      a0 = add_cnt;
      fpu_mode = 0;
      t0 = cyc;
      for (int k = 0; k < 20 && cmd_ready !== 1'b1; k++) tick;
      chk("fifo_ready_after_pop", 32'(cmd_ready), 32'd1);
      chk("fifo_pop_latency", 32'(cyc - t0), 32'd2);
      tick;
      cmd_valid = 1'b0;
      wait_done("q_done0", t1); tick;
      wait_done("q_done1", t1); tick;
      wait_done("q_done2", t1); tick;
      chk("q_adds", 32'(add_cnt - a0), 32'd3);
      rdchk("q_reg0", 2'd0, 7'd4, 15'h4000);
      rdchk("q_reg1", 2'd1, 7'd5, 15'h4000);
      rdchk("q_reg3", 2'd3, 7'd5, 15'h4000);

      // FPU ignores the start pulse
      hw(2'd0, 7'd1, 15'h0001);
      fpu_mode = 1;
      push(2'b00, 2'd2, 2'd1, 2'd1);
      push(2'b01, 2'd0, 2'd2, 2'd0);
      cmd_valid = 1'b0;
      wait_add("sw_add", ta);
      wait_err1("sw_err");
      chk("sw_err_latency", 32'(cyc - ta), 32'd4);
      chk("sw_done", 32'(done), 32'd1);
      tick;
      wait_done("sw_next_done", t1);
      tick;
      rdchk("sw_reg2_kept", 2'd2, 7'd4, 15'h4000);
      rdchk("sw_mov_reg0", 2'd0, 7'd4, 15'h4000);
      err_clr = 1'b1;
      tick;
      err_clr = 1'b0;
      chk("err_clr", 32'(err), 32'd0);

      // FPU never finishes
      fpu_mode = 2;
      push(2'b00, 2'd1, 2'd0, 2'd0);
      cmd_valid = 1'b0;
      wait_add("to_add", ta);
      wait_err1("to_err");
      chk("to_err_latency", 32'(cyc - ta), 32'd257);
      chk("to_done", 32'(done), 32'd1);
      chk("to_opa_held", 32'({fpu_a_e, fpu_a_m}), 32'({7'd4, 15'h4000}));
      fpu_mode = 0;
      tick;
      rdchk("to_reg1_kept", 2'd1, 7'd5, 15'h4000);
      wait_idle;

      // reserved opcode, set beating a simultaneous clear
      err_clr = 1'b1;
      push(2'b11, 2'd1, 2'd0, 2'd0);
      cmd_valid = 1'b0;
      chk("rsv_cleared", 32'(err), 32'd0);
      tick;
      chk("rsv_set_wins", 32'(err), 32'd1);
      chk("rsv_done", 32'(done), 32'd1);
      err_clr = 1'b0;
      tick;
      chk("rsv_sticky", 32'(err), 32'd1);
      rdchk("rsv_reg1_kept", 2'd1, 7'd5, 15'h4000);
      err_clr = 1'b1;
      tick;
      err_clr = 1'b0;
      chk("rsv_clr", 32'(err), 32'd0);

      // reset while waiting for the FPU result
      push(2'b00, 2'd2, 2'd0, 2'd0);
      cmd_valid = 1'b0;
      wait_add("rst_mid_add", ta);
      tick; tick; tick;
      chk("rst_mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick;
      chk("rst_mid_idle", 32'(busy), 32'd0);
      chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
      chk("rst_mid_add0", 32'(fpu_add), 32'd0);
      chk("rst_mid_opa", 32'({fpu_a_e, fpu_a_m}), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) rdchk("rst_mid_reg", 2'(i), 7'd0, 15'h0);
      wait_idle;
      rdchk("rst_no_wb", 2'd2, 7'd0, 15'h0);

      // host write during WB is dropped
      hw(2'd3, 7'd7, 15'h0123);
      push(2'b01, 2'd0, 2'd3, 2'd0);
      cmd_valid = 1'b0;
      tick;
      chk("wb_wr_ready", 32'(host_wr_ready), 32'd0);
      host_wr_en = 1'b1; host_wr_idx = 2'd2; host_wr_e = 7'd9; host_wr_m = 15'h0009;
      tick;
      host_wr_en = 1'b0;
      chk("wb_done", 32'(done), 32'd1);
      chk("wb_wr_ready_back", 32'(host_wr_ready), 32'd1);
      rdchk("wb_drop_reg2", 2'd2, 7'd0, 15'h0);
      rdchk("wb_mov_reg0", 2'd0, 7'd7, 15'h0123);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
